// File: rtl/sdram_arbiter_n_pkg.sv
// Shared state encoding and arbitration-mode constants for the SDRAM bridge arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } arb_state_e;

  localparam int ARB_FIXED  = 32'sd0;
  localparam int ARB_RR     = 32'sd1;
  localparam int ARB_HYBRID = 32'sd2;

  localparam int DEF_ADDR_W = 32'sd22;
  localparam int DEF_DATA_W = 32'sd128;

endpackage

// File: rtl/sdram_arbiter_n_rr_picker.sv
// Rotating-priority picker: first requester in req_i & mask_i at or after ptr_i, wrapping at N-1.
// A zero pointer turns it into a plain lowest-index priority encoder.
module rr_picker #(
  parameter int  N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0] cand;
  logic [N-1:0] rot;
  logic [IW:0]  off;
  logic [IW:0]  sum;

  assign cand    = req_i & mask_i;
  assign rot     = N'({cand, cand} >> ptr_i);
  assign valid_o = |cand;

  // Downward scan leaves the smallest offset from the pointer in off.
  always_comb begin
    off = {(IW + 1){1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      off = rot[k] ? (IW + 1)'(k) : off;
    end
    sum   = {1'b0, ptr_i} + off;
    idx_o = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
  end

endmodule

// File: rtl/sdram_arbiter_n.sv
// N-client arbiter serialising line read/write requests onto the single SDRAM bridge port.
// Fixed, round-robin or hybrid selection at each idle decision; bridge timeout sets a sticky error.
module sdram_arbiter_n
  import sdram_arb_pkg::*;
#(
  parameter int                   N_CLIENTS = 8,
  parameter int                   ADDR_W    = DEF_ADDR_W,
  parameter int                   DATA_W    = DEF_DATA_W,
  parameter int                   ARB_MODE  = ARB_HYBRID,
  parameter logic [N_CLIENTS-1:0] RT_MASK   = N_CLIENTS'(8'b0000_0011),
  parameter int                   TIMEOUT   = 1023,
  localparam int                  IDX_W     = $clog2(N_CLIENTS),
  localparam int                  BE_W      = DATA_W / 32'sd8,
  localparam int                  CNT_W     = $clog2(TIMEOUT + 32'sd1)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [N_CLIENTS-1:0]          cli_rd_i,
  input  logic [N_CLIENTS-1:0]          cli_wr_i,
  input  logic [N_CLIENTS*ADDR_W-1:0]   cli_addr_i,
  input  logic [N_CLIENTS*DATA_W-1:0]   cli_wrdata_i,
  input  logic [N_CLIENTS*BE_W-1:0]     cli_be_i,
  output logic [N_CLIENTS-1:0]          cli_ac_o,
  output logic [N_CLIENTS-1:0]          cli_wait_o,
  output logic [DATA_W-1:0]             rddata_o,
  output logic [ADDR_W+3:0]             bridge_address_o,
  output logic [BE_W-1:0]               bridge_byte_enable_o,
  output logic                          bridge_read_o,
  output logic                          bridge_write_o,
  output logic [DATA_W-1:0]             bridge_write_data_o,
  input  logic                          bridge_acknowledge_i,
  input  logic [DATA_W-1:0]             bridge_read_data_i,
  output logic [IDX_W-1:0]              grant_id_o,
  output logic                          timeout_err_o
);

  localparam logic [N_CLIENTS-1:0] ALL_ONES = {N_CLIENTS{1'b1}};
  localparam logic [N_CLIENTS-1:0] NONE     = {N_CLIENTS{1'b0}};
  // Mode 0 puts everyone on the fixed picker, mode 1 everyone on the rotating one.
  localparam logic [N_CLIENTS-1:0] FIX_MASK =
    (ARB_MODE == ARB_FIXED) ? ALL_ONES : ((ARB_MODE == ARB_HYBRID) ? RT_MASK : NONE);
  localparam logic [N_CLIENTS-1:0] RR_MASK =
    (ARB_MODE == ARB_RR) ? ALL_ONES : ((ARB_MODE == ARB_HYBRID) ? ~RT_MASK : NONE);

  arb_state_e           state_q;
  logic [N_CLIENTS-1:0] req;
  logic [N_CLIENTS-1:0] cli_ac_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     ptr_d;
  logic [IDX_W-1:0]     grant_q;
  logic [IDX_W-1:0]     fix_idx;
  logic [IDX_W-1:0]     rr_idx;
  logic [IDX_W-1:0]     win_idx;
  logic                 fix_valid;
  logic                 rr_valid;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wrdata;
  logic [BE_W-1:0]      sel_be;
  logic                 sel_wr;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_W-1:0]    rddata_q;
  logic [DATA_W-1:0]    wrdata_q;
  logic [ADDR_W+3:0]    addr_q;
  logic [BE_W-1:0]      be_q;
  logic                 rd_q;
  logic                 wr_q;
  logic                 err_q;

  assign req        = cli_rd_i | cli_wr_i;
  assign cli_wait_o = req & ~cli_ac_q;

  rr_picker #(.N(N_CLIENTS)) u_fix_pick (
    .req_i   (req),
    .mask_i  (FIX_MASK),
    .ptr_i   ({IDX_W{1'b0}}),
    .valid_o (fix_valid),
    .idx_o   (fix_idx)
  );

  rr_picker #(.N(N_CLIENTS)) u_rr_pick (
    .req_i   (req),
    .mask_i  (RR_MASK),
    .ptr_i   (ptr_q),
    .valid_o (rr_valid),
    .idx_o   (rr_idx)
  );

  assign win_idx = fix_valid ? fix_idx : rr_idx;
  assign ptr_d   = (rr_idx == IDX_W'(N_CLIENTS - 32'sd1)) ? {IDX_W{1'b0}} : rr_idx + IDX_W'(1);

  // AND-OR mux of the winning client's address, data, byte enables and direction.
  always_comb begin
    sel_addr   = {ADDR_W{1'b0}};
    sel_wrdata = {DATA_W{1'b0}};
    sel_be     = {BE_W{1'b0}};
    sel_wr     = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      sel_addr   = sel_addr   | (cli_addr_i[i*ADDR_W +: ADDR_W]   & {ADDR_W{win_idx == IDX_W'(i)}});
      sel_wrdata = sel_wrdata | (cli_wrdata_i[i*DATA_W +: DATA_W] & {DATA_W{win_idx == IDX_W'(i)}});
      sel_be     = sel_be     | (cli_be_i[i*BE_W +: BE_W]         & {BE_W{win_idx == IDX_W'(i)}});
      sel_wr     = sel_wr     | (cli_wr_i[i] & (win_idx == IDX_W'(i)));
    end
  end

  // Arbitration FSM; every output it drives is registered here.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      ptr_q    <= {IDX_W{1'b0}};
      grant_q  <= {IDX_W{1'b0}};
      cli_ac_q <= {N_CLIENTS{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      rddata_q <= {DATA_W{1'b0}};
      wrdata_q <= {DATA_W{1'b0}};
      addr_q   <= {(ADDR_W + 4){1'b0}};
      be_q     <= {BE_W{1'b0}};
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cli_ac_q <= {N_CLIENTS{1'b0}};
      case (state_q)
        S_IDLE: begin
          if (fix_valid || rr_valid) begin
            grant_q  <= win_idx;
            addr_q   <= {sel_addr, 4'b0000};
            be_q     <= sel_be;
            wrdata_q <= sel_wrdata;
            wr_q     <= sel_wr;
            rd_q     <= ~sel_wr;
            cnt_q    <= {CNT_W{1'b0}};
            state_q  <= S_ISSUE;
            // Real-time grants leave the rotation untouched.
            if (!fix_valid) begin
              ptr_q <= ptr_d;
            end
          end
        end
        S_ISSUE: begin
          if (bridge_acknowledge_i) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            if (rd_q) begin
              rddata_q <= bridge_read_data_i;
            end
            cli_ac_q[grant_q] <= 1'b1;
            state_q           <= S_DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 32'sd1)) begin
            rd_q              <= 1'b0;
            wr_q              <= 1'b0;
            err_q             <= 1'b1;
            rddata_q          <= {DATA_W{1'b0}};
            cli_ac_q[grant_q] <= 1'b1;
            state_q           <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cli_ac_o             = cli_ac_q;
  assign rddata_o             = rddata_q;
  assign bridge_address_o     = addr_q;
  assign bridge_byte_enable_o = be_q;
  assign bridge_read_o        = rd_q;
  assign bridge_write_o       = wr_q;
  assign bridge_write_data_o  = wrdata_q;
  assign grant_id_o           = grant_q;
  assign timeout_err_o        = err_q;

endmodule

// File: tb/tb_sdram_arbiter_n.sv
// Directed bench: hybrid arbiter (TIMEOUT=15) for transactions, timeout and reset; round-robin copy for rotation.
module tb_sdram_arbiter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic [7:0]     cli_rd, cli_wr, cli_ac, cli_wait;
  logic [175:0]   cli_addr;
  logic [1023:0]  cli_wrdata;
  logic [127:0]   cli_be;
  logic [127:0]   rddata, bridge_wdata, bridge_rdata;
  logic [25:0]    bridge_address;
  logic [15:0]    bridge_be;
  logic           bridge_read, bridge_write, bridge_ack, timeout_err;
  logic [2:0]     grant_id;

  logic [7:0]     b_rd, b_wr, b_ac, b_wait;
  logic [175:0]   b_addr;
  logic [1023:0]  b_wd;
  logic [127:0]   b_be, b_rddata, b_bwd, b_brdata;
  logic [25:0]    b_baddr;
  logic [15:0]    b_bbe;
  logic           b_bread, b_bwrite, b_ack, b_err;
  logic [2:0]     b_grant;

  sdram_arbiter_n #(.ARB_MODE(2), .TIMEOUT(15)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .cli_rd_i(cli_rd), .cli_wr_i(cli_wr),
    .cli_addr_i(cli_addr), .cli_wrdata_i(cli_wrdata), .cli_be_i(cli_be),
    .cli_ac_o(cli_ac), .cli_wait_o(cli_wait), .rddata_o(rddata),
    .bridge_address_o(bridge_address), .bridge_byte_enable_o(bridge_be),
    .bridge_read_o(bridge_read), .bridge_write_o(bridge_write),
    .bridge_write_data_o(bridge_wdata), .bridge_acknowledge_i(bridge_ack),
    .bridge_read_data_i(bridge_rdata), .grant_id_o(grant_id), .timeout_err_o(timeout_err)
  );

  sdram_arbiter_n #(.ARB_MODE(1), .TIMEOUT(15)) dut_rr (
    .clk_i(clk), .reset_n_i(reset_n), .cli_rd_i(b_rd), .cli_wr_i(b_wr),
    .cli_addr_i(b_addr), .cli_wrdata_i(b_wd), .cli_be_i(b_be),
    .cli_ac_o(b_ac), .cli_wait_o(b_wait), .rddata_o(b_rddata),
    .bridge_address_o(b_baddr), .bridge_byte_enable_o(b_bbe),
    .bridge_read_o(b_bread), .bridge_write_o(b_bwrite),
    .bridge_write_data_o(b_bwd), .bridge_acknowledge_i(b_ack),
    .bridge_read_data_i(b_brdata), .grant_id_o(b_grant), .timeout_err_o(b_err)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cycles       = 0;
  logic [127:0] model_rd;

  localparam logic [127:0] D1  = 128'hDEAD_0011_2233_4455_6677_8899_AABB_BEEF;
  localparam logic [127:0] WD2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cycles++;
  endtask

  // Caller sets the requests in an idle cycle; grant happens at the next edge, ack k cycles later.
  task automatic serve(input int id, input bit is_wr, input int k, input logic [127:0] d,
                       input logic [25:0] exp_addr, input logic [15:0] exp_be,
                       input logic [7:0] raise);
    cyc();
    chk("grant_id", grant_id, id);
    chk("bridge_read", bridge_read, !is_wr);
    chk("bridge_write", bridge_write, is_wr);
    chk("bridge_address", bridge_address, exp_addr);
    chk("bridge_be", bridge_be, exp_be);
    chk("wait_issue", cli_wait[id], 1'b1);
    chk("ac_issue", cli_ac, 8'h00);
    cli_rd = cli_rd | raise;
    for (int i = 1; i < k; i++) cyc();
    bridge_ack   = 1'b1;
    bridge_rdata = d;
    cyc();
    bridge_ack   = 1'b0;
    bridge_rdata = 128'h0;
    chk("cli_ac", cli_ac, 8'd1 << id);
    chk("wait_done", cli_wait[id], 1'b0);
    chk("bridge_idle", {bridge_read, bridge_write}, 2'b00);
    if (!is_wr) model_rd = d;
    chk("rddata", rddata, model_rd);
    cli_rd[id] = 1'b0;
    cli_wr[id] = 1'b0;
    cyc();
    chk("ac_clear", cli_ac, 8'h00);
  endtask

  int order [3];
  int n_hi, guard, prev, w;

  initial begin
    reset_n = 1'b0; cli_rd = 8'h00; cli_wr = 8'h00; cli_wrdata = '0;
    bridge_ack = 1'b0; bridge_rdata = 128'h0; model_rd = 128'h0;
    b_rd = 8'h00; b_wr = 8'h00; b_addr = '0; b_wd = '0; b_be = '0; b_ack = 1'b0;
    b_brdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    for (int i = 0; i < 8; i++) begin
      cli_addr[i*22 +: 22] = 22'h000100 + 22'(i);
      cli_be[i*16 +: 16]   = 16'hFFFF;
    end
    cli_addr[3*22 +: 22]  = 22'h0ABCD;
    cli_addr[2*22 +: 22]  = 22'h3FFFFF;
    cli_be[2*16 +: 16]    = 16'h00FF;
    cli_wrdata[2*128 +: 128] = WD2;

    repeat (3) cyc();
    chk("rst_read", bridge_read, 1'b0);
    chk("rst_write", bridge_write, 1'b0);
    chk("rst_ac", cli_ac, 8'h00);
    chk("rst_wait", cli_wait, 8'h00);
    chk("rst_rddata", rddata, 128'h0);
    chk("rst_addr", bridge_address, 26'h0);
    chk("rst_grant", grant_id, 3'd0);
    chk("rst_err", timeout_err, 1'b0);
    reset_n = 1'b1;
    cyc();

    // Acknowledge while idle must be ignored.
    bridge_ack = 1'b1; bridge_rdata = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    cyc();
    bridge_ack = 1'b0; bridge_rdata = 128'h0;
    chk("stray_ac", cli_ac, 8'h00);
    chk("stray_rddata", rddata, 128'h0);
    cyc();

    // Single read from client 3, ack after 5 cycles.
    cli_rd[3] = 1'b1;
    serve(3, 1'b0, 5, D1, 26'h00ABCD0, 16'hFFFF, 8'h00);

    // Read+write together: only the write goes out; read data kept.
    cli_rd[2] = 1'b1; cli_wr[2] = 1'b1;
    serve(2, 1'b1, 1, 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0, 26'h3FFFFF0, 16'h00FF, 8'h00);
    chk("bridge_wdata", bridge_wdata, WD2);

    // No acknowledge: abort after 15 ISSUE cycles.
    cli_rd[7] = 1'b1;
    cyc();
    chk("to_grant", grant_id, 3'd7);
    n_hi = 0; guard = 0;
    while (cli_ac === 8'h00 && guard < 40) begin
      if (bridge_read === 1'b1) n_hi++;
      cyc();
      guard++;
    end
    chk("to_len", n_hi, 15);
    chk("to_ac", cli_ac, 8'h80);
    chk("to_read", bridge_read, 1'b0);
    chk("to_rddata", rddata, 128'h0);
    chk("to_err", timeout_err, 1'b1);
    model_rd = 128'h0;
    cli_rd[7] = 1'b0;
    cyc();
    cli_rd[1] = 1'b1;
    serve(1, 1'b0, 3, 128'hCAFE, 26'h0001010, 16'hFFFF, 8'h00);
    chk("err_sticky", timeout_err, 1'b1);

    // Hybrid: RT client 0 arrives during client 5's transaction and jumps ahead of 6.
    cli_rd = 8'b0110_0000;
    serve(5, 1'b0, 2, 128'h5, 26'h0001050, 16'hFFFF, 8'h01);
    serve(0, 1'b0, 2, 128'h0A, 26'h0001000, 16'hFFFF, 8'h00);
    serve(6, 1'b0, 2, 128'h6, 26'h0001060, 16'hFFFF, 8'h00);

    // RT clients by lowest index, then the non-RT one.
    cli_rd = 8'b0001_0011;
    serve(0, 1'b0, 1, 128'h100, 26'h0001000, 16'hFFFF, 8'h00);
    serve(1, 1'b0, 1, 128'h101, 26'h0001010, 16'hFFFF, 8'h00);
    serve(4, 1'b0, 1, 128'h104, 26'h0001040, 16'hFFFF, 8'h00);

    // Reset during ISSUE (pointer is at 5 beforehand).
    cli_rd[4] = 1'b1;
    cyc();
    chk("pre_rst_read", bridge_read, 1'b1);
    reset_n = 1'b0; cli_rd = 8'h00;
    cyc();
    chk("mid_rst_read", bridge_read, 1'b0);
    chk("mid_rst_ac", cli_ac, 8'h00);
    chk("mid_rst_grant", grant_id, 3'd0);
    chk("mid_rst_addr", bridge_address, 26'h0);
    chk("mid_rst_rddata", rddata, 128'h0);
    chk("mid_rst_err", timeout_err, 1'b0);
    model_rd = 128'h0;
    reset_n = 1'b1; bridge_ack = 1'b1; bridge_rdata = 128'h77;
    cyc();
    bridge_ack = 1'b0; bridge_rdata = 128'h0;
    chk("late_ack_ac", cli_ac, 8'h00);
    chk("late_ack_rddata", rddata, 128'h0);
    cli_rd = 8'b0100_0100;
    serve(2, 1'b0, 2, 128'h22, 26'h3FFFFF0, 16'h00FF, 8'h00);
    serve(6, 1'b0, 2, 128'h66, 26'h0001060, 16'hFFFF, 8'h00);

    // Round-robin copy: clients 1, 4, 6 held high, ack one cycle after read rises.
    order[0] = 1; order[1] = 4; order[2] = 6;
    prev = 0;
    b_rd = 8'b0101_0010;
    for (int n = 0; n < 6; n++) begin
      w = 0;
      while (b_bread !== 1'b1 && w < 20) begin
        cyc();
        w++;
      end
      chk("rr_issue", b_bread, 1'b1);
      chk("rr_grant", b_grant, order[n % 3]);
      if (n > 0) chk("rr_period", cycles - prev, 4);
      prev = cycles;
      cyc();
      b_ack = 1'b1;
      cyc();
      b_ack = 1'b0;
      chk("rr_ac", b_ac, 8'd1 << order[n % 3]);
    end
    chk("rr_err", b_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter_n.md
Name: sdram_arbiter_n

Overview:
Parametrised N-client arbiter placed in front of the SDRAM controller bridge (128-bit line, 22-bit line address). It serialises read/write requests from frame drawers, line buffer, audio streamer and init loaders onto the single bridge port. It supports fixed-priority, round-robin or hybrid arbitration, where real-time clients (audio, line buffer) pre-empt others between transactions. It adds a bridge timeout with a sticky error flag and per-client wait/acknowledge handshakes.

Parameters:
N_CLIENTS, 8, number of requesters (2..16)
ADDR_W, 22, line address width (bridge byte address = {addr, 4'b0000})
DATA_W, 128, data width; byte-enable width = DATA_W/8
ARB_MODE, 2, 0 = fixed priority (index 0 highest), 1 = round-robin, 2 = hybrid (RT_MASK clients fixed-priority, others round-robin)
RT_MASK, 8'b0000_0011, real-time client bitmask, used only in mode 2
TIMEOUT, 1023, maximum cycles spent waiting for bridge_acknowledge before abort

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  synchronous, active-low reset
cli_rd  in  N_CLIENTS  per-client read request, level, held until cli_ac
cli_wr  in  N_CLIENTS  per-client write request, level, held until cli_ac
cli_addr  in  N_CLIENTS*ADDR_W  packed line addresses, client i at [i*ADDR_W +: ADDR_W]
cli_wrdata  in  N_CLIENTS*DATA_W  packed write data
cli_be  in  N_CLIENTS*DATA_W/8  packed byte enables
cli_ac  out  N_CLIENTS  one-cycle completion pulse
cli_wait  out  N_CLIENTS  high while client request pending and not yet completed
rddata  out  DATA_W  registered read data, valid in the cycle cli_ac pulses
bridge_address  out  ADDR_W+4  byte address to controller
bridge_byte_enable  out  DATA_W/8
bridge_read  out  1
bridge_write  out  1
bridge_write_data  out  DATA_W
bridge_acknowledge  in  1  one-cycle completion from controller; read data valid same cycle
bridge_read_data  in  DATA_W
grant_id  out  $clog2(N_CLIENTS)  index of current/last granted client
timeout_err  out  1  sticky; set on bridge timeout, cleared only by reset

Behaviour:
- Reset (reset_n low at clk edge): state IDLE; all outputs 0; RR pointer 0; timeout counter 0; timeout_err 0.
- req[i] = cli_rd[i] | cli_wr[i]. When both are set, a write is performed; cli_rd is ignored for that transaction.
- FSM IDLE -> ISSUE -> DONE -> IDLE.
- IDLE: if any req, pick winner w; register grant_id=w, bridge address/be/wrdata from client w, and assert bridge_read or bridge_write on the next cycle (state ISSUE). With no req, stay idle and keep bridge_read/write at 0.
- ISSUE: hold bridge signals stable and count cycles. On bridge_acknowledge: deassert bridge_read/write, latch rddata=bridge_read_data (write: rddata unchanged), go to DONE. If count reaches TIMEOUT: deassert bridge_read/write, set timeout_err, rddata=0, go to DONE.
- DONE: cli_ac[grant_id]=1 for exactly this cycle, then IDLE. The earliest next grant is registered in the following IDLE cycle, so there are 2 dead cycles between bridge transactions.
- Latency: request seen in IDLE at cycle t -> bridge_read high at t+1 -> ack at t+k -> cli_ac at t+k+1.
- cli_wait[i] = req[i] & ~cli_ac[i]; it is combinational from req and is 0 when no request is present.
- Winner selection:
  - Mode 0: lowest index wins.
  - Mode 1: first requester at or after RR pointer, with wrap-around from N_CLIENTS-1 to 0; pointer becomes w+1 (mod N) at grant.
  - Mode 2: any RT_MASK requester wins by lowest index; otherwise the mode-1 rule over non-RT clients, and the pointer advances only on non-RT grants.
- Requests are never pre-empted mid-transaction; pre-emption applies only at the IDLE decision.
- A client dropping its request while granted is a protocol violation; the transaction still completes and cli_ac still pulses.
- bridge_acknowledge outside ISSUE is ignored.
- Reset mid-transaction aborts immediately with no cli_ac, and bridge_read/write are low after the reset edge.

Decomposition:
- Package sdram_arb_pkg: state enum (S_IDLE, S_ISSUE, S_DONE), ARB_MODE constants (ARB_FIXED, ARB_RR, ARB_HYBRID), DATA_W/ADDR_W defaults.
- Sub-module rr_picker (combinational): inputs request vector, mask and pointer; outputs a valid flag and the winner index. It is instantiated once for the RT subset and once for the round-robin subset.

Test Plan:
- Single read, client 3, addr 22'h0ABCD; bridge ack after 5 cycles with data 128'hDEAD..BEEF -> bridge_address=26'h0ABCD0 at t+1, cli_ac[3] at t+6, rddata=DEAD..BEEF, other cli_ac=0.
- Mode 1, clients 1, 4 and 6 request continuously, ack after 1 cycle -> grant order 1,4,6,1,4,6; a new grant every 4 cycles.
- Mode 2, RT_MASK=0b11: clients 5 and 6 pending, client 0 raises a request while client 5 is in ISSUE -> client 5 completes, then 0, then 6.
- Client 2 asserts cli_rd and cli_wr together with be=16'h00FF -> only bridge_write=1, bridge_byte_enable=16'h00FF; rddata unchanged.
- TIMEOUT=15 with no bridge ack -> bridge_read drops after 15 cycles, timeout_err=1 and stays set, cli_ac pulses with rddata=0, next client is served normally.
- reset_n low during ISSUE -> next cycle all outputs 0, no cli_ac, late bridge_acknowledge ignored, arbitration restarts at pointer 0.
